// File: rtl/mul_pkg.sv
// Shared constants for the 32x32 multiplier datapath: partial-product
// geometry and the row count at each Wallace reduction level.
package mul_pkg;

  localparam int PP_NUM = 17;
  localparam int PP_W   = 64;

  // Rows present at the input of each reduction level (level 0 = raw rows).
  localparam int ROWS_L0 = 17;
  localparam int ROWS_L1 = 12;
  localparam int ROWS_L2 = 8;
  localparam int ROWS_L3 = 6;
  localparam int ROWS_L4 = 4;
  localparam int ROWS_L5 = 3;
  localparam int ROWS_L6 = 2;

  // Last CSA level evaluated before the first pipeline register.
  localparam int STAGE1_LAST_LEVEL = 3;

endpackage : mul_pkg

// File: rtl/csa_3to2.sv
// Row of full adders: compresses three W-bit vectors into a sum and a
// left-shifted carry vector. The carry out of bit W-1 is dropped, which is
// what makes the whole tree compute modulo 2^W.
module csa_3to2 #(
  parameter int W = 64
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_sum,
  output logic [W-1:0] o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_c;
  assign o_carry = {((i_a[W-2:0] & i_b[W-2:0]) |
                     (i_a[W-2:0] & i_c[W-2:0]) |
                     (i_b[W-2:0] & i_c[W-2:0])), 1'b0};

endmodule : csa_3to2

// File: rtl/wallace_reduce_pipe.sv
// Three-stage Wallace-tree reducer and final adder for the 17 Booth radix-4
// partial-product rows. S1: CSA levels 1-3, S2: CSA levels 4-6, S3: 64-bit
// carry-propagate add. Valid/ready on both sides with full backpressure;
// empty stages fill even while a later stage is stalled.
// Optional feature: define WALLACE_FLUSH_EN to add the flush input, which
// drops every in-flight result at the next edge without touching data.
module wallace_reduce_pipe
  import mul_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
`ifdef WALLACE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PP_W-1:0]  pp0,
  input  logic [PP_W-1:0]  pp1,
  input  logic [PP_W-1:0]  pp2,
  input  logic [PP_W-1:0]  pp3,
  input  logic [PP_W-1:0]  pp4,
  input  logic [PP_W-1:0]  pp5,
  input  logic [PP_W-1:0]  pp6,
  input  logic [PP_W-1:0]  pp7,
  input  logic [PP_W-1:0]  pp8,
  input  logic [PP_W-1:0]  pp9,
  input  logic [PP_W-1:0]  pp10,
  input  logic [PP_W-1:0]  pp11,
  input  logic [PP_W-1:0]  pp12,
  input  logic [PP_W-1:0]  pp13,
  input  logic [PP_W-1:0]  pp14,
  input  logic [PP_W-1:0]  pp15,
  input  logic [PP_W-1:0]  pp16,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PP_W-1:0]  out_prod,
  output logic [TAG_W-1:0] out_tag
);

  logic w_flush;
`ifdef WALLACE_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // ---------------------------------------------------------------- handshake
  logic r_v1, r_v2, r_out_valid;
  logic w_out_adv, w_s2_adv, w_s1_adv;

  // A stage advances when it is empty or the stage after it advances.
  assign w_out_adv = !r_out_valid || out_ready;
  assign w_s2_adv  = !r_v2 || w_out_adv;
  assign w_s1_adv  = !r_v1 || w_s2_adv;
  assign in_ready  = w_s1_adv && !w_flush;

  // ------------------------------------------------------- stage 1 tree (L1-L3)
  logic [ROWS_L0-1:0][PP_W-1:0] w_l0;
  logic [ROWS_L1-1:0][PP_W-1:0] w_l1;
  logic [ROWS_L2-1:0][PP_W-1:0] w_l2;
  logic [ROWS_L3-1:0][PP_W-1:0] w_l3;

  assign w_l0 = {pp16, pp15, pp14, pp13, pp12, pp11, pp10, pp9, pp8,
                 pp7, pp6, pp5, pp4, pp3, pp2, pp1, pp0};

  for (genvar g = 0; g < ROWS_L0 / 3; g++) begin : g_lvl1
    csa_3to2 #(.W(PP_W)) u_csa (
      .i_a(w_l0[3*g]), .i_b(w_l0[3*g+1]), .i_c(w_l0[3*g+2]),
      .o_sum(w_l1[2*g]), .o_carry(w_l1[2*g+1]));
  end
  for (genvar g = 0; g < ROWS_L0 % 3; g++) begin : g_pass1
    assign w_l1[2*(ROWS_L0/3)+g] = w_l0[3*(ROWS_L0/3)+g];
  end

  for (genvar g = 0; g < ROWS_L1 / 3; g++) begin : g_lvl2
    csa_3to2 #(.W(PP_W)) u_csa (
      .i_a(w_l1[3*g]), .i_b(w_l1[3*g+1]), .i_c(w_l1[3*g+2]),
      .o_sum(w_l2[2*g]), .o_carry(w_l2[2*g+1]));
  end
  for (genvar g = 0; g < ROWS_L1 % 3; g++) begin : g_pass2
    assign w_l2[2*(ROWS_L1/3)+g] = w_l1[3*(ROWS_L1/3)+g];
  end

  for (genvar g = 0; g < ROWS_L2 / 3; g++) begin : g_lvl3
    csa_3to2 #(.W(PP_W)) u_csa (
      .i_a(w_l2[3*g]), .i_b(w_l2[3*g+1]), .i_c(w_l2[3*g+2]),
      .o_sum(w_l3[2*g]), .o_carry(w_l3[2*g+1]));
  end
  for (genvar g = 0; g < ROWS_L2 % 3; g++) begin : g_pass3
    assign w_l3[2*(ROWS_L2/3)+g] = w_l2[3*(ROWS_L2/3)+g];
  end

  logic [ROWS_L3-1:0][PP_W-1:0] r_s1_rows;
  logic [TAG_W-1:0]             r_s1_tag;

  // Stage-1 register: capture the six rows and tag when S1 advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_s1_rows <= '0;
      r_s1_tag  <= '0;
    end else if (w_flush) begin
      r_v1      <= 1'b0;
    end else if (w_s1_adv) begin
      r_v1      <= in_valid;
      r_s1_rows <= w_l3;
      r_s1_tag  <= in_tag;
    end else begin
      r_v1      <= r_v1;
    end
  end

  // ------------------------------------------------------- stage 2 tree (L4-L6)
  logic [ROWS_L4-1:0][PP_W-1:0] w_l4;
  logic [ROWS_L5-1:0][PP_W-1:0] w_l5;
  logic [ROWS_L6-1:0][PP_W-1:0] w_l6;

  for (genvar g = 0; g < ROWS_L3 / 3; g++) begin : g_lvl4
    csa_3to2 #(.W(PP_W)) u_csa (
      .i_a(r_s1_rows[3*g]), .i_b(r_s1_rows[3*g+1]), .i_c(r_s1_rows[3*g+2]),
      .o_sum(w_l4[2*g]), .o_carry(w_l4[2*g+1]));
  end
  for (genvar g = 0; g < ROWS_L3 % 3; g++) begin : g_pass4
    assign w_l4[2*(ROWS_L3/3)+g] = r_s1_rows[3*(ROWS_L3/3)+g];
  end

  for (genvar g = 0; g < ROWS_L4 / 3; g++) begin : g_lvl5
    csa_3to2 #(.W(PP_W)) u_csa (
      .i_a(w_l4[3*g]), .i_b(w_l4[3*g+1]), .i_c(w_l4[3*g+2]),
      .o_sum(w_l5[2*g]), .o_carry(w_l5[2*g+1]));
  end
  for (genvar g = 0; g < ROWS_L4 % 3; g++) begin : g_pass5
    assign w_l5[2*(ROWS_L4/3)+g] = w_l4[3*(ROWS_L4/3)+g];
  end

  for (genvar g = 0; g < ROWS_L5 / 3; g++) begin : g_lvl6
    csa_3to2 #(.W(PP_W)) u_csa (
      .i_a(w_l5[3*g]), .i_b(w_l5[3*g+1]), .i_c(w_l5[3*g+2]),
      .o_sum(w_l6[2*g]), .o_carry(w_l6[2*g+1]));
  end
  for (genvar g = 0; g < ROWS_L5 % 3; g++) begin : g_pass6
    assign w_l6[2*(ROWS_L5/3)+g] = w_l5[3*(ROWS_L5/3)+g];
  end

  logic [PP_W-1:0]  r_s2_sum, r_s2_carry;
  logic [TAG_W-1:0] r_s2_tag;

  // Stage-2 register: capture the final sum/carry pair when S2 advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2       <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_carry <= '0;
      r_s2_tag   <= '0;
    end else if (w_flush) begin
      r_v2       <= 1'b0;
    end else if (w_s2_adv) begin
      r_v2       <= r_v1;
      r_s2_sum   <= w_l6[0];
      r_s2_carry <= w_l6[1];
      r_s2_tag   <= r_s1_tag;
    end else begin
      r_v2       <= r_v2;
    end
  end

  // ------------------------------------------------------- stage 3 final add
  logic [PP_W-1:0]  r_out_prod;
  logic [TAG_W-1:0] r_out_tag;

  // Output register: carry-propagate add; holds steady while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_prod  <= '0;
      r_out_tag   <= '0;
    end else if (w_flush) begin
      r_out_valid <= 1'b0;
    end else if (w_out_adv) begin
      r_out_valid <= r_v2;
      r_out_prod  <= r_s2_sum + r_s2_carry;
      r_out_tag   <= r_s2_tag;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid = r_out_valid;
  assign out_prod  = r_out_prod;
  assign out_tag   = r_out_tag;

endmodule : wallace_reduce_pipe

// File: tb/tb_wallace_reduce_pipe.sv
// Self-checking bench for wallace_reduce_pipe. Rows are generated with a
// Booth radix-4 encoder; expected products come from a plain 64-bit multiply
// and are kept in an in-order scoreboard keyed by handshake transfers.
module tb_wallace_reduce_pipe;

  localparam int TAG_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, in_valid, out_ready;
  logic             in_ready, out_valid;
  logic [63:0]      pp [17];
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [63:0]      out_prod;
`ifdef WALLACE_FLUSH_EN
  logic             flush;
`endif

  wallace_reduce_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
`ifdef WALLACE_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready),
    .pp0(pp[0]), .pp1(pp[1]), .pp2(pp[2]), .pp3(pp[3]), .pp4(pp[4]),
    .pp5(pp[5]), .pp6(pp[6]), .pp7(pp[7]), .pp8(pp[8]), .pp9(pp[9]),
    .pp10(pp[10]), .pp11(pp[11]), .pp12(pp[12]), .pp13(pp[13]),
    .pp14(pp[14]), .pp15(pp[15]), .pp16(pp[16]),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_tag(out_tag)
  );

  int checks = 0;
  int failures = 0;
  int n_acc = 0;
  int n_out = 0;
  logic [63:0]      q_prod [$];
  logic [TAG_W-1:0] q_tag  [$];
  logic [63:0]      nxt_prod;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ext32(input logic [31:0] v, input bit s);
    return s ? {{32{v[31]}}, v} : {32'd0, v};
  endfunction

  // Booth radix-4 rows for A*B, plus the reference product.
  task automatic load_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                         input logic [TAG_W-1:0] t);
    logic [63:0] ax, mag;
    logic [34:0] bx;
    logic [2:0]  tr;
    ax = ext32(a, s);
    bx = {(s ? {2{b[31]}} : 2'b00), b, 1'b0};
    for (int i = 0; i < 17; i++) begin
      tr = bx[2*i+2 -: 3];
      case (tr)
        3'b001, 3'b010: mag = ax;
        3'b011:         mag = ax << 1;
        3'b100:         mag = -(ax << 1);
        3'b101, 3'b110: mag = -ax;
        default:        mag = 64'd0;
      endcase
      pp[i] = mag << (2*i);
    end
    in_tag   = t;
    nxt_prod = ax * ext32(b, s);
  endtask

  // One clock: observe transfers just before the edge, update scoreboard.
  task automatic tick();
    logic fi, fo;
    logic [63:0] op;
    logic [TAG_W-1:0] ot;
    @(negedge clk);
    fi = in_valid && in_ready && !rst;
    fo = out_valid && out_ready && !rst;
    op = out_prod;
    ot = out_tag;
    if (fo) begin
      n_out++;
      checks++;
      assert (q_prod.size() != 0) else begin
        failures++;
        $error("FAIL spurious_output observed=0x%016h expected=no_output", op);
      end
      if (q_prod.size() != 0) begin
        chk("sb_prod", op, q_prod.pop_front());
        chk("sb_tag", 64'(ot), 64'(q_tag.pop_front()));
      end
    end
    if (fi) begin
      q_prod.push_back(nxt_prod);
      q_tag.push_back(in_tag);
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  // Single transaction with constant expectation and latency measurement.
  task automatic run_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input bit s, input logic [TAG_W-1:0] t, input logic [63:0] exp);
    int lat;
    out_ready = 1'b1;
    load_op(a, b, s, t);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd3);
    chk({nm, "_prod"}, out_prod, exp);
    chk({nm, "_tag"}, 64'(out_tag), 64'(t));
    tick();
  endtask

  initial begin
    int n_ov, pa;
    bit acc;
    logic [63:0] held;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
`ifdef WALLACE_FLUSH_EN
    flush = 1'b0;
`endif
    load_op(32'd0, 32'd0, 1'b0, 5'd0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_prod", out_prod, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    run_one("u7x9", 32'd7, 32'd9, 1'b0, 5'h0b, 64'h3F);
    run_one("sm1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'h11, 64'h1);
    run_one("umax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'h1f, 64'hFFFFFFFE00000001);
    run_one("smin", 32'h80000000, 32'h80000000, 1'b1, 5'h02, 64'h4000000000000000);

    // 8 back-to-back random operands
    n_ov = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k < 8) begin
        load_op($urandom, $urandom, 1'($urandom_range(0, 1)), TAG_W'($urandom));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (k >= 3 && out_valid) n_ov++;
      if (k < 3 && out_valid) n_ov += 100;
      tick();
    end
    chk("b2b_valid_cycles", 64'(n_ov), 64'd8);
    chk("b2b_drained", 64'(q_prod.size()), 64'd0);

    // stall with streaming input
    n_acc = 0;
    out_ready = 1'b0;
    held = 64'd0;
    for (int k = 0; k < 6; k++) begin
      load_op($urandom, $urandom, 1'($urandom_range(0, 1)), TAG_W'($urandom));
      in_valid = 1'b1;
      tick();
      if (k == 3) held = out_prod;
    end
    chk("stall_accepted", 64'(n_acc), 64'd3);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_prod_stable", out_prod, held);
    chk("stall_prod_value", out_prod, q_prod[0]);
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("release_accepted", 64'(n_acc), 64'd4);
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("stall_drained", 64'(q_prod.size()), 64'd0);

    // reset with two products in flight
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      load_op($urandom, $urandom, 1'b0, TAG_W'($urandom));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_prod.delete();
    q_tag.delete();
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    n_ov = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid) n_ov++;
      tick();
    end
    chk("midrst_no_output", 64'(n_ov), 64'd0);
    run_one("post_rst_3x5", 32'd3, 32'd5, 1'b0, 5'h07, 64'd15);

`ifdef WALLACE_FLUSH_EN
    // flush a full pipe
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      load_op($urandom, $urandom, 1'b1, TAG_W'($urandom));
      in_valid = 1'b1;
      tick();
    end
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    q_prod.delete();
    q_tag.delete();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    n_ov = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid) n_ov++;
      tick();
    end
    chk("flush_no_stale", 64'(n_ov), 64'd0);
    run_one("post_flush_3x5", 32'd3, 32'd5, 1'b0, 5'h09, 64'd15);
`endif

    // random soak with random backpressure
    acc = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (!in_valid || acc) begin
        load_op($urandom, $urandom, 1'($urandom_range(0, 1)), TAG_W'($urandom));
        in_valid = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      pa = n_acc;
      tick();
      acc = (n_acc != pa);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    chk("soak_drained", 64'(q_prod.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_wallace_reduce_pipe
